// File: rtl/ha_pkg.sv
// Shared definitions for the registered half adder and its lane cell.
package ha_pkg;

  // Width of one lane's evaluated result: {carry, sum}.
  localparam int unsigned HA_EVAL_W = 2;

  // Per-lane reset values of the output registers.
  localparam logic HA_RST_SUM   = 1'b0;
  localparam logic HA_RST_CARRY = 1'b0;

  // One lane's result; carry is the MSB so the packed value equals a + b.
  typedef struct packed {
    logic carry;
    logic sum;
  } ha_res_t;

  // Single-bit half-adder evaluation, shared by the datapath and the properties.
  function automatic ha_res_t ha_eval(input logic a, input logic b);
    ha_res_t res;
    res.sum   = a ^ b;
    res.carry = a & b;
    return res;
  endfunction

endpackage : ha_pkg

// File: rtl/half_adder_lane.sv
// Combinational single-bit half-adder cell; one instance per lane.
module half_adder_lane
  import ha_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum_c,
  output logic carry_c
);

  ha_res_t res_c;

  // Evaluate the lane through the shared function so datapath and properties agree.
  always_comb begin
    res_c   = ha_eval(a, b);
    sum_c   = res_c.sum;
    carry_c = res_c.carry;
  end

endmodule : half_adder_lane

// File: rtl/half_adder_reg.sv
// Registered multi-lane half adder: sum = a ^ b, carry = a & b, one cycle of latency.
// Lanes are fully independent; there is no carry between lanes.
module half_adder_reg
  import ha_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;

  // One combinational cell per lane.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .a       (a[i]),
      .b       (b[i]),
      .sum_c   (sum_c[i]),
      .carry_c (carry_c[i])
    );
  end

  // Output registers: cleared asynchronously, reloaded on every edge out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum       <= {WIDTH{HA_RST_SUM}};
      carry     <= {WIDTH{HA_RST_CARRY}};
      out_valid <= 1'b0;
    end else begin
      sum       <= sum_c;
      carry     <= carry_c;
      out_valid <= 1'b1;
    end
  end

`ifdef FORMAL
  logic             f_past_valid = 1'b0;
  logic [WIDTH-1:0] f_past_a;
  logic [WIDTH-1:0] f_past_b;
  logic             f_past_rstn;
  logic             f_seen_release = 1'b0;
  logic [WIDTH-1:0] f_exp_sum;
  logic [WIDTH-1:0] f_exp_carry;

  // Past copies of the inputs, sampled on the same edge as the outputs.
  always_ff @(posedge clk) begin
    f_past_valid <= 1'b1;
    f_past_a     <= a;
    f_past_b     <= b;
    f_past_rstn  <= rstn;
    if (f_past_valid && rstn) f_seen_release <= 1'b1;
  end

  // Expected outputs rebuilt from the past inputs through the shared function.
  always_comb begin
    f_exp_sum   = '0;
    f_exp_carry = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      f_exp_sum[i]   = ha_eval(f_past_a[i], f_past_b[i]).sum;
      f_exp_carry[i] = ha_eval(f_past_a[i], f_past_b[i]).carry;
    end
  end

  // Start the trace in reset.
  always_comb begin
    if (!f_past_valid) assume (!rstn);
  end

  // Outputs are cleared whenever reset is held.
  always_comb begin
    if (!rstn) assert (sum == '0 && carry == '0 && !out_valid);
  end

  // A valid result is the half-adder of the previously sampled inputs.
  always_comb begin
    if (f_past_valid && rstn && out_valid) begin
      assert (sum == f_exp_sum);
      assert (carry == f_exp_carry);
    end
  end

  // Sum and carry are never both set in a lane.
  always_comb begin
    assert ((sum & carry) == '0);
  end

  // Reachability of the interesting output and reset scenarios.
  always_comb begin
    cover (out_valid && carry != '0);
    cover (out_valid && sum != '0);
    cover (f_seen_release && !rstn);
  end
`endif

endmodule : half_adder_reg

// File: tb/tb_half_adder_reg.sv
// Directed bench for half_adder_reg: a 1-lane instance and a 4-lane instance on a shared clock/reset.
module tb_half_adder_reg;

  logic       clk;
  logic       rstn;
  logic       a1, b1;
  logic       sum1, carry1, ov1;
  logic [3:0] a4, b4;
  logic [3:0] sum4, carry4;
  logic       ov4;

  int checks;
  int failures;

  half_adder_reg #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .a         (a1),
    .b         (b1),
    .sum       (sum1),
    .carry     (carry1),
    .out_valid (ov1)
  );

  half_adder_reg #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rstn      (rstn),
    .a         (a4),
    .b         (b4),
    .sum       (sum4),
    .carry     (carry4),
    .out_valid (ov4)
  );

  always #5 clk = ~clk;

  // Reset held for two edges with a=1, b=0: everything stays 0.
  task automatic test_reset();
    rstn = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    a4 = 4'b1111; b4 = 4'b0000;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      checks++;
      if ({sum1, carry1, ov1} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold edge%0d: got {sum,carry,ov}=%b want 000", e, {sum1, carry1, ov1});
      end
      checks++;
      if ({sum4, carry4, ov4} !== 9'b0) begin
        failures++;
        $display("FAIL reset_hold_w4 edge%0d: got %b want 000000000", e, {sum4, carry4, ov4});
      end
    end
  endtask

  // Release reset with a=1, b=0: first edge loads sum=1 and raises out_valid.
  task automatic test_release();
    @(negedge clk);
    rstn = 1'b1;
    a1 = 1'b1; b1 = 1'b0;
    #1;
    checks++;
    if ({sum1, carry1, ov1} !== 3'b000) begin
      failures++;
      $display("FAIL release_pre_edge: got %b want 000", {sum1, carry1, ov1});
    end
    @(posedge clk); #1;
    checks++;
    if ({sum1, carry1, ov1} !== 3'b101) begin
      failures++;
      $display("FAIL release_first_edge: got {sum,carry,ov}=%b want 101", {sum1, carry1, ov1});
    end
  endtask

  // All four input combinations, one per edge.
  task automatic test_sweep();
    logic [1:0] vin [4];
    logic [1:0] vexp [4];
    vin[0] = 2'b00; vexp[0] = 2'b00;
    vin[1] = 2'b01; vexp[1] = 2'b10;
    vin[2] = 2'b10; vexp[2] = 2'b10;
    vin[3] = 2'b11; vexp[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = vin[i][1]; b1 = vin[i][0];
      @(posedge clk); #1;
      checks++;
      if ({sum1, carry1, ov1} !== {vexp[i], 1'b1}) begin
        failures++;
        $display("FAIL sweep_ab%b: got {sum,carry,ov}=%b want %b", vin[i], {sum1, carry1, ov1}, {vexp[i], 1'b1});
      end
    end
  endtask

  // 11 then 00: carry holds for exactly one cycle.
  task automatic test_latency();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sum1, carry1} !== 2'b01) begin
      failures++;
      $display("FAIL latency_carry_set: got {sum,carry}=%b want 01", {sum1, carry1});
    end
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0;
    #1;
    checks++;
    if ({sum1, carry1} !== 2'b01) begin
      failures++;
      $display("FAIL latency_carry_hold: got {sum,carry}=%b want 01", {sum1, carry1});
    end
    @(posedge clk); #1;
    checks++;
    if ({sum1, carry1, ov1} !== 3'b001) begin
      failures++;
      $display("FAIL latency_clear: got {sum,carry,ov}=%b want 001", {sum1, carry1, ov1});
    end
  endtask

  // Reset asserted between edges clears outputs before the next edge and holds them.
  task automatic test_async_reset();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0;
    a4 = 4'b0011; b4 = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if ({sum1, carry1, ov1} !== 3'b101) begin
      failures++;
      $display("FAIL async_pre: got {sum,carry,ov}=%b want 101", {sum1, carry1, ov1});
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({sum1, carry1, ov1} !== 3'b000) begin
      failures++;
      $display("FAIL async_clear: got {sum,carry,ov}=%b want 000", {sum1, carry1, ov1});
    end
    checks++;
    if ({sum4, carry4, ov4} !== 9'b0) begin
      failures++;
      $display("FAIL async_clear_w4: got %b want 000000000", {sum4, carry4, ov4});
    end
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sum1, carry1, ov1} !== 3'b000) begin
      failures++;
      $display("FAIL async_hold: got {sum,carry,ov}=%b want 000", {sum1, carry1, ov1});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sum1, carry1, ov1} !== 3'b011) begin
      failures++;
      $display("FAIL async_rerelease: got {sum,carry,ov}=%b want 011", {sum1, carry1, ov1});
    end
  endtask

  // Four-lane vectors: each lane independent, no carry between lanes.
  task automatic test_width4();
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic [3:0] es [4];
    logic [3:0] ec [4];
    va[0] = 4'b1010; vb[0] = 4'b0110; es[0] = 4'b1100; ec[0] = 4'b0010;
    va[1] = 4'b1111; vb[1] = 4'b1111; es[1] = 4'b0000; ec[1] = 4'b1111;
    va[2] = 4'b0101; vb[2] = 4'b1010; es[2] = 4'b1111; ec[2] = 4'b0000;
    va[3] = 4'b1000; vb[3] = 4'b1001; es[3] = 4'b0001; ec[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a4 = va[i]; b4 = vb[i];
      @(posedge clk); #1;
      checks++;
      if ({sum4, carry4, ov4} !== {es[i], ec[i], 1'b1}) begin
        failures++;
        $display("FAIL width4_v%0d: got sum=%b carry=%b ov=%b want sum=%b carry=%b ov=1",
                 i, sum4, carry4, ov4, es[i], ec[i]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk  = 1'b0;
    rstn = 1'b1;
    a1 = 1'b0; b1 = 1'b0;
    a4 = '0;   b4 = '0;
    #1;
    test_reset();
    test_release();
    test_sweep();
    test_latency();
    test_async_reset();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_half_adder_reg
